// File: rtl/decode_stage_pkg.sv
// LC-3b shared types for the decode stage: words, register indices,
// opcodes and the ID/EX pipeline bundle.
package decode_stage_pkg;

    localparam int NREGS = 8;
    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] lc3b_word;
    typedef logic [2:0]       lc3b_reg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef struct packed {
        logic     valid;
        lc3b_word pc;
        lc3b_word ir;
        lc3b_reg  sr1;
        lc3b_reg  sr2;
        lc3b_word sr1_data;
        lc3b_word sr2_data;
        lc3b_reg  dest;
        logic     regwrite;
    } id_ex_t;

    function automatic logic is_load(lc3b_opcode op);
        return (op == OP_LDB) || (op == OP_LDI) || (op == OP_LDR);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID input, control, writeback port and the
// ID/EX register outputs.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic     if_id_valid;
    lc3b_word if_id_pc;
    lc3b_word if_id_ir;
    logic     mem_stall;
    logic     flush;
    logic     wb_load;
    lc3b_reg  wb_dest;
    lc3b_word wb_data;
    logic     stall_fetch;
    logic     id_ex_valid;
    lc3b_word id_ex_pc;
    lc3b_word id_ex_ir;
    lc3b_reg  id_ex_sr1;
    lc3b_reg  id_ex_sr2;
    lc3b_word id_ex_sr1_data;
    lc3b_word id_ex_sr2_data;
    lc3b_reg  id_ex_dest;
    logic     id_ex_regwrite;

    modport master (
        output if_id_valid, if_id_pc, if_id_ir,
        output mem_stall, flush,
        output wb_load, wb_dest, wb_data,
        input  stall_fetch, id_ex_valid,
        input  id_ex_pc, id_ex_ir,
        input  id_ex_sr1, id_ex_sr2,
        input  id_ex_sr1_data, id_ex_sr2_data,
        input  id_ex_dest, id_ex_regwrite
    );

    modport slave (
        input  if_id_valid, if_id_pc, if_id_ir,
        input  mem_stall, flush,
        input  wb_load, wb_dest, wb_data,
        output stall_fetch, id_ex_valid,
        output id_ex_pc, id_ex_ir,
        output id_ex_sr1, id_ex_sr2,
        output id_ex_sr1_data, id_ex_sr2_data,
        output id_ex_dest, id_ex_regwrite
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// Register file: one write port, two async read ports; a write in
// flight is forwarded to the readers in the same cycle.
module decode_stage_regfile #(
    parameter  int NREGS = 8,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (we && waddr == raddr1) ? wdata : regs_q[raddr1];
    assign rdata2 = (we && waddr == raddr2) ? wdata : regs_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// LC-3b decode stage: operand decode, register read, load-use
// hazard detection and the ID/EX pipeline register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int NREGS = decode_stage_pkg::NREGS,
    parameter int WIDTH = decode_stage_pkg::WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);

    lc3b_opcode op;
    lc3b_reg    sr1, sr2, dest;
    logic       uses_sr1, uses_sr2, regwrite;
    lc3b_word   sr1_data, sr2_data;
    logic       hz;
    id_ex_t     id_ex_q, id_ex_d;

    assign op = lc3b_opcode'(bus.if_id_ir[15:12]);

    always_comb begin
        sr1      = bus.if_id_ir[8:6];
        sr2      = bus.if_id_ir[2:0];
        dest     = bus.if_id_ir[11:9];
        uses_sr1 = 1'b0;
        uses_sr2 = 1'b0;
        regwrite = 1'b0;
        unique case (op)
            OP_ADD, OP_AND: begin
                uses_sr1 = 1'b1;
                uses_sr2 = ~bus.if_id_ir[5];
                regwrite = 1'b1;
            end
            OP_NOT, OP_SHF, OP_LDB, OP_LDI, OP_LDR: begin
                uses_sr1 = 1'b1;
                regwrite = 1'b1;
            end
            OP_LEA: regwrite = 1'b1;
            OP_STB, OP_STI, OP_STR: begin
                uses_sr1 = 1'b1;
                uses_sr2 = 1'b1;
                sr2      = bus.if_id_ir[11:9];
            end
            OP_JMP: uses_sr1 = 1'b1;
            OP_JSR: begin
                // JSRR (ir[11]=0) jumps through BaseR
                uses_sr1 = ~bus.if_id_ir[11];
                regwrite = 1'b1;
                dest     = 3'b111;
            end
            OP_TRAP: begin
                regwrite = 1'b1;
                dest     = 3'b111;
            end
            default: ;
        endcase
        regwrite = regwrite & bus.if_id_valid;
    end

    decode_stage_regfile #(
        .NREGS(NREGS),
        .WIDTH(WIDTH)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.wb_load),
        .waddr  (bus.wb_dest),
        .wdata  (bus.wb_data),
        .raddr1 (sr1),
        .raddr2 (sr2),
        .rdata1 (sr1_data),
        .rdata2 (sr2_data)
    );

    assign hz = bus.if_id_valid & id_ex_q.valid
              & is_load(lc3b_opcode'(id_ex_q.ir[15:12]))
              & id_ex_q.regwrite
              & ((uses_sr1 & (sr1 == id_ex_q.dest))
               | (uses_sr2 & (sr2 == id_ex_q.dest)));

    assign bus.stall_fetch = bus.mem_stall | (hz & ~bus.flush);

    always_comb begin
        id_ex_d = id_ex_q;
        if (bus.flush) begin
            id_ex_d.valid    = 1'b0;
            id_ex_d.regwrite = 1'b0;
        end else if (bus.mem_stall) begin
            id_ex_d = id_ex_q;
        end else if (hz) begin
            id_ex_d.valid    = 1'b0;
            id_ex_d.regwrite = 1'b0;
        end else begin
            id_ex_d.valid    = bus.if_id_valid;
            id_ex_d.pc       = bus.if_id_pc;
            id_ex_d.ir       = bus.if_id_ir;
            id_ex_d.sr1      = sr1;
            id_ex_d.sr2      = sr2;
            id_ex_d.sr1_data = sr1_data;
            id_ex_d.sr2_data = sr2_data;
            id_ex_d.dest     = dest;
            id_ex_d.regwrite = regwrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) id_ex_q <= '0;
        else        id_ex_q <= id_ex_d;
    end

    assign bus.id_ex_valid    = id_ex_q.valid;
    assign bus.id_ex_pc       = id_ex_q.pc;
    assign bus.id_ex_ir       = id_ex_q.ir;
    assign bus.id_ex_sr1      = id_ex_q.sr1;
    assign bus.id_ex_sr2      = id_ex_q.sr2;
    assign bus.id_ex_sr1_data = id_ex_q.sr1_data;
    assign bus.id_ex_sr2_data = id_ex_q.sr2_data;
    assign bus.id_ex_dest     = id_ex_q.dest;
    assign bus.id_ex_regwrite = id_ex_q.regwrite;

endmodule
